// File: rtl/pv1000_ram_upload.sv
// Upload responder for the PV-1000: serves hps_io ioctl_rd byte requests from the shared RAM.
// Optional feature macro: UPLOAD_CHECKSUM_EN appends a 16-bit byte sum at addresses SIZE and SIZE+1.
module pv1000_ram_upload #(
    parameter int          ADDR_W      = 16,
    parameter int          SIZE        = 65536,
    parameter int          RD_LAT      = 1,
    parameter logic [7:0]  FILL        = 8'hFF,
    parameter logic [23:0] ACK_TIMEOUT = 24'd5000000
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              save_trigger,
    output logic              upload_req,
    input  logic              ioctl_upload,
    input  logic              ioctl_rd,
    input  logic [24:0]       ioctl_addr,
    output logic [7:0]        ioctl_din,
    output logic              ioctl_wait,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_rd,
    input  logic [7:0]        mem_q,
    output logic              busy
);

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_ACK, S_ARMED, S_FETCH} state_t;
    typedef enum logic [1:0] {SRC_RAM, SRC_FILL, SRC_SUM_LO, SRC_SUM_HI} src_t;

    localparam logic [25:0] SIZE_W  = 26'(SIZE);
    localparam logic [1:0]  LAT_END = 2'(RD_LAT);

    state_t      state;
    src_t        src;
    src_t        addr_src;
    logic        trig_prev;
    logic [23:0] ack_cnt;
    logic [23:0] ack_nxt;
    logic [1:0]  lat_cnt;
    logic [25:0] addr_ext;
`ifdef UPLOAD_CHECKSUM_EN
    logic [15:0] sum;
`endif

    assign addr_ext = {1'b0, ioctl_addr};
    assign ack_nxt  = ack_cnt + 24'd1;

    always_comb begin
        addr_src = SRC_FILL;
        if (addr_ext < SIZE_W)
            addr_src = SRC_RAM;
`ifdef UPLOAD_CHECKSUM_EN
        else if (addr_ext == SIZE_W)
            addr_src = SRC_SUM_LO;
        else if (addr_ext == SIZE_W + 26'd1)
            addr_src = SRC_SUM_HI;
`endif
    end

    // The request itself stalls the HPS in the same cycle, before the FSM has reacted.
    assign ioctl_wait = ioctl_rd | (state == S_FETCH);
    assign upload_req = (state == S_REQ);
    assign busy       = (state != S_IDLE);

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state     <= S_IDLE;
            src       <= SRC_FILL;
            trig_prev <= 1'b1;  // a trigger held through reset is not an edge
            ack_cnt   <= '0;
            lat_cnt   <= '0;
            mem_rd    <= 1'b0;
            mem_a     <= '0;
            ioctl_din <= FILL;
`ifdef UPLOAD_CHECKSUM_EN
            sum       <= '0;
`endif
        end else begin
            trig_prev <= save_trigger;
            mem_rd    <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (save_trigger && !trig_prev)
                        state <= S_REQ;
                end
                S_REQ: begin
                    ack_cnt <= '0;
                    state   <= S_ACK;
                end
                S_ACK: begin
                    if (ioctl_upload) begin
                        state <= S_ARMED;
`ifdef UPLOAD_CHECKSUM_EN
                        sum   <= '0;
`endif
                    end else begin
                        ack_cnt <= ack_nxt;
                        if (ack_nxt == ACK_TIMEOUT)
                            state <= S_IDLE;
                    end
                end
                S_ARMED: begin
                    if (!ioctl_upload) begin
                        state <= S_IDLE;
                    end else if (ioctl_rd) begin
                        src     <= addr_src;
                        lat_cnt <= '0;
                        state   <= S_FETCH;
                        if (addr_src == SRC_RAM) begin
                            mem_rd <= 1'b1;
                            mem_a  <= ioctl_addr[ADDR_W-1:0];
                        end
                    end
                end
                S_FETCH: begin
                    if (!ioctl_upload) begin
                        state <= S_IDLE;
                    end else if (lat_cnt == LAT_END) begin
                        // Every source waits out the RAM latency so delivery timing never depends on the address.
                        state <= S_ARMED;
                        case (src)
                            SRC_RAM: begin
                                ioctl_din <= mem_q;
`ifdef UPLOAD_CHECKSUM_EN
                                sum       <= sum + {8'd0, mem_q};
`endif
                            end
`ifdef UPLOAD_CHECKSUM_EN
                            SRC_SUM_LO: ioctl_din <= sum[7:0];
                            SRC_SUM_HI: ioctl_din <= sum[15:8];
`endif
                            default:    ioctl_din <= FILL;
                        endcase
                    end else begin
                        lat_cnt <= lat_cnt + 2'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pv1000_ram_upload.sv
// Randomized bench for pv1000_ram_upload: RAM image and expected bytes come from a plain array model.
module tb_pv1000_ram_upload;

    localparam int          ADDR_W  = 16;
    localparam int          SIZE    = 16384;
    localparam int          RD_LAT  = 1;
    localparam logic [7:0]  FILL    = 8'hFF;
    localparam int          TIMEOUT = 100;

    logic              clk_sys = 1'b0;
    logic              reset;
    logic              save_trigger;
    logic              upload_req;
    logic              ioctl_upload;
    logic              ioctl_rd;
    logic [24:0]       ioctl_addr;
    logic [7:0]        ioctl_din;
    logic              ioctl_wait;
    logic [ADDR_W-1:0] mem_a;
    logic              mem_rd;
    logic [7:0]        mem_q;
    logic              busy;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0]  ram [0:(1<<ADDR_W)-1];
    logic [7:0]  q_pipe [RD_LAT];
    logic [7:0]  din_model;
    logic [15:0] sum_model;

    pv1000_ram_upload #(
        .ADDR_W(ADDR_W), .SIZE(SIZE), .RD_LAT(RD_LAT), .FILL(FILL), .ACK_TIMEOUT(24'(TIMEOUT))
    ) dut (
        .clk_sys(clk_sys), .reset(reset), .save_trigger(save_trigger), .upload_req(upload_req),
        .ioctl_upload(ioctl_upload), .ioctl_rd(ioctl_rd), .ioctl_addr(ioctl_addr),
        .ioctl_din(ioctl_din), .ioctl_wait(ioctl_wait), .mem_a(mem_a), .mem_rd(mem_rd),
        .mem_q(mem_q), .busy(busy)
    );

    always #5 clk_sys = ~clk_sys;

    // RAM: data is valid exactly RD_LAT cycles after mem_rd, junk otherwise.
    always @(posedge clk_sys) begin
        if (mem_rd) q_pipe[0] <= ram[mem_a];
        else        q_pipe[0] <= 8'($urandom);
        for (int i = 1; i < RD_LAT; i++) q_pipe[i] <= q_pipe[i-1];
    end
    assign mem_q = q_pipe[RD_LAT-1];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick;
        @(negedge clk_sys);
    endtask

    function automatic logic [7:0] expected_byte(input logic [24:0] a);
        if (int'(a) < SIZE) return ram[a[ADDR_W-1:0]];
`ifdef UPLOAD_CHECKSUM_EN
        if (int'(a) == SIZE)     return sum_model[7:0];
        if (int'(a) == SIZE + 1) return sum_model[15:8];
`endif
        return FILL;
    endfunction

    task automatic start_session;
        save_trigger = 1'b0;
        tick;
        save_trigger = 1'b1;
        tick;
        check("req_pulse", upload_req, 1'b1);
        check("busy_req", busy, 1'b1);
        ioctl_upload = 1'b1;
        tick;
        check("req_one_cycle", upload_req, 1'b0);
        save_trigger = 1'b0;
        tick;
        check("armed_wait_low", ioctl_wait, 1'b0);
        sum_model = 16'd0;
    endtask

    task automatic end_session;
        ioctl_upload = 1'b0;
        tick;
        check("busy_end", busy, 1'b0);
    endtask

    task automatic do_read(input logic [24:0] a, input int gap);
        logic [7:0] exp;
        bit         in_range;
        int         n_rd;
        int         off;
        repeat (gap) tick;
        in_range = int'(a) < SIZE;
        exp      = expected_byte(a);
        check("din_hold", ioctl_din, din_model);
        ioctl_rd   = 1'b1;
        ioctl_addr = a;
        #1;
        check("wait_on_rd", ioctl_wait, 1'b1);
        tick;
        ioctl_rd   = 1'b0;
        ioctl_addr = 25'($urandom);
        n_rd = int'(mem_rd);
        if (in_range) check("mem_a", mem_a, a[ADDR_W-1:0]);
        off = 1;
        for (int k = 2; k < 16; k++) begin
            tick;
            off = k;
            n_rd += int'(mem_rd);
            if (!ioctl_wait) break;
        end
        check("latency", off, RD_LAT + 2);
        check("din", ioctl_din, exp);
        check("mem_rd_count", n_rd, in_range ? 1 : 0);
        din_model = exp;
        if (in_range) sum_model = sum_model + 16'(exp);
    endtask

    function automatic logic [24:0] pick_addr;
        case ($urandom_range(0, 6))
            0:       return 25'd0;
            1:       return 25'(SIZE - 1);
            2:       return 25'(SIZE);
            3:       return 25'(SIZE + 1);
            4:       return 25'($urandom);
            default: return 25'($urandom_range(0, SIZE - 1));
        endcase
    endfunction

    initial begin
        int busy_cycles;
        int req_count;

        for (int i = 0; i < (1 << ADDR_W); i++) ram[i] = 8'($urandom);
        ram[16'h1234] = 8'h5A;
        reset        = 1'b1;
        save_trigger = 1'b1;
        ioctl_upload = 1'b0;
        ioctl_rd     = 1'b0;
        ioctl_addr   = '0;
        din_model    = FILL;
        sum_model    = 16'd0;
        repeat (3) tick;
        check("rst_upload_req", upload_req, 1'b0);
        check("rst_mem_rd", mem_rd, 1'b0);
        check("rst_mem_a", mem_a, '0);
        check("rst_din", ioctl_din, FILL);
        check("rst_busy", busy, 1'b0);
        check("rst_wait", ioctl_wait, 1'b0);
        reset = 1'b0;
        // Trigger held high out of reset must not start an upload.
        req_count = 0;
        repeat (5) begin
            tick;
            req_count += int'(upload_req) + int'(busy);
        end
        check("no_req_after_reset", req_count, 0);

        // Basic read of a known byte.
        start_session;
        do_read(25'h1234, 0);
        check("busy_during", busy, 1'b1);
        do_read(25'h4000, 1);
        end_session;

        // Randomized sessions with mixed addresses and gaps.
        for (int s = 0; s < 3; s++) begin
            start_session;
            for (int r = 0; r < 25; r++) do_read(pick_addr(), $urandom_range(0, 3));
            do_read(25'(SIZE), 0);
            do_read(25'(SIZE + 1), 0);
            end_session;
            repeat ($urandom_range(1, 4)) tick;
        end

        // Timeout with ioctl_upload held low.
        save_trigger = 1'b0;
        tick;
        save_trigger = 1'b1;
        busy_cycles = 0;
        req_count   = 0;
        for (int k = 0; k < 300; k++) begin
            tick;
            req_count += int'(upload_req);
            if (!busy) break;
            busy_cycles++;
        end
        check("timeout_busy_cycles", busy_cycles, TIMEOUT + 1);
        check("timeout_req_count", req_count, 1);
        start_session;
        do_read(25'(SIZE - 1), 0);

        // Abort in the middle of a fetch.
        ioctl_rd   = 1'b1;
        ioctl_addr = 25'h0100;
        tick;
        ioctl_rd     = 1'b0;
        ioctl_upload = 1'b0;
        check("abort_mem_rd", mem_rd, 1'b1);
        tick;
        check("abort_busy", busy, 1'b0);
        check("abort_wait", ioctl_wait, 1'b0);
        check("abort_din", ioctl_din, din_model);
        req_count = 0;
        repeat (4) begin
            tick;
            req_count += int'(mem_rd);
        end
        check("abort_no_mem_rd", req_count, 0);
        check("abort_din_later", ioctl_din, din_model);

        // Reset in the middle of a fetch, trigger held high across it.
        start_session;
        do_read(25'h1234, 0);
        ioctl_rd   = 1'b1;
        ioctl_addr = 25'h0200;
        tick;
        ioctl_rd     = 1'b0;
        reset        = 1'b1;
        save_trigger = 1'b1;
        tick;
        reset = 1'b0;
        din_model = FILL;
        check("mrst_upload_req", upload_req, 1'b0);
        check("mrst_mem_rd", mem_rd, 1'b0);
        check("mrst_mem_a", mem_a, '0);
        check("mrst_din", ioctl_din, FILL);
        check("mrst_busy", busy, 1'b0);
        check("mrst_wait", ioctl_wait, 1'b0);
        ioctl_rd = 1'b1;
        #1;
        check("mrst_wait_follows_rd", ioctl_wait, 1'b1);
        ioctl_rd = 1'b0;
        req_count = 0;
        repeat (6) begin
            tick;
            req_count += int'(upload_req) + int'(busy);
        end
        check("mrst_no_req", req_count, 0);
        check("mrst_din_held", ioctl_din, FILL);
        ioctl_upload = 1'b0;

        // A fresh session still works after the mid-fetch reset.
        start_session;
        do_read(pick_addr(), 0);
        do_read(25'(SIZE), 0);
        end_session;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
